// File: rtl/accel_dispatch_if.sv
// Bundle of CPU command, data-memory and accelerator-mux signals for accel_dispatch_unit.
// master = dispatch unit side, slave = environment (CPU, memory, accelerator mux).
interface accel_dispatch_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_sel;
  logic [7:0]   cmd_op;
  logic [7:0]   cmd_src;
  logic [7:0]   cmd_par;
  logic [7:0]   cmd_dst;

  logic         mem_req;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic [7:0]   mem_rdata;
  logic         mem_ack;

  logic [1:0]   acc_sel;
  logic [7:0]   acc_op;
  logic         acc_enable;
  logic [127:0] acc_data;
  logic [127:0] acc_param;
  logic [127:0] acc_result;
  logic         acc_done;
  logic         acc_error;

  logic         busy;
  logic         rsp_valid;
  logic [1:0]   rsp_status;
  logic [3:0]   q_count;

  modport master (
    input  cmd_valid, cmd_sel, cmd_op, cmd_src, cmd_par, cmd_dst,
    output cmd_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output acc_sel, acc_op, acc_enable, acc_data, acc_param,
    input  acc_result, acc_done, acc_error,
    output busy, rsp_valid, rsp_status, q_count
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_op, cmd_src, cmd_par, cmd_dst,
    input  cmd_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  acc_sel, acc_op, acc_enable, acc_data, acc_param,
    output acc_result, acc_done, acc_error,
    input  busy, rsp_valid, rsp_status, q_count
  );
endinterface

// File: rtl/accel_dispatch_unit.sv
// Accelerator command front end: queues commands, gathers operands byte-wise from memory,
// runs the selected accelerator with a timeout, stores the result and reports a status.
module accel_dispatch_unit #(
  parameter int TIMEOUT = 255,
  parameter int QDEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  accel_dispatch_if.master bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_P, EXEC, STORE, RESP} state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] op;
    logic [7:0] src;
    logic [7:0] par;
    logic [7:0] dst;
  } cmd_t;

  state_t        state;
  cmd_t          fifo_mem [QDEPTH];
  cmd_t          head;
  cmd_t          active;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    count;
  logic          push;
  logic          pop;
  logic          ack_hit;
  logic [3:0]    idx;
  logic [3:0]    idx_next;
  logic [7:0]    tcnt;
  logic [127:0]  data_buf;
  logic [127:0]  param_buf;
  logic [127:0]  result_buf;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [7:0]    mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          acc_enable_q;
  logic          rsp_valid_q;
  logic [1:0]    rsp_status_q;

  // Readiness comes from the registered count, so a same-cycle pop frees nothing yet.
  assign bus.cmd_ready = (count < 4'(QDEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != 4'd0);
  assign head          = fifo_mem[rd_ptr];
  assign ack_hit       = mem_req_q && bus.mem_ack;
  assign idx_next      = idx + 4'd1;

  // NOTE: queue storage is deliberately left without reset; only pointers and count
  // define validity, and a resettable RAM would block memory inference.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{sel: bus.cmd_sel, op: bus.cmd_op, src: bus.cmd_src,
                                    par: bus.cmd_par, dst: bus.cmd_dst};
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: ;
      endcase
    end
  end

  // Memory and accelerator strobes are registers cleared by the async reset, so an
  // in-flight request or run is dropped the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      active       <= '0;
      idx          <= '0;
      tcnt         <= '0;
      data_buf     <= '0;
      param_buf    <= '0;
      result_buf   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      acc_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            active <= head;
            idx    <= '0;
            if (head.sel == 2'd3) begin
              state        <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= 2'd3;
            end else begin
              state      <= LOAD_D;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= head.src;
            end
          end
        end

        LOAD_D: begin
          if (ack_hit) begin
            data_buf[{idx, 3'b000} +: 8] <= bus.mem_rdata;
            idx <= idx_next;
            if (idx == 4'd15) begin
              state      <= LOAD_P;
              mem_addr_q <= active.par;
            end else begin
              mem_addr_q <= active.src + 8'(idx_next);
            end
          end
        end

        LOAD_P: begin
          if (ack_hit) begin
            param_buf[{idx, 3'b000} +: 8] <= bus.mem_rdata;
            idx <= idx_next;
            if (idx == 4'd15) begin
              state        <= EXEC;
              mem_req_q    <= 1'b0;
              acc_enable_q <= 1'b1;
              tcnt         <= '0;
            end else begin
              mem_addr_q <= active.par + 8'(idx_next);
            end
          end
        end

        EXEC: begin
          // A done arriving on the timeout cycle is checked first and therefore wins.
          if (bus.acc_done) begin
            result_buf   <= bus.acc_result;
            acc_enable_q <= 1'b0;
            idx          <= '0;
            if (bus.acc_error) begin
              state        <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= 2'd1;
            end else begin
              state       <= STORE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= active.dst;
              mem_wdata_q <= bus.acc_result[7:0];
            end
          end else if (tcnt == 8'(TIMEOUT)) begin
            acc_enable_q <= 1'b0;
            state        <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= 2'd2;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        STORE: begin
          if (ack_hit) begin
            idx <= idx_next;
            if (idx == 4'd15) begin
              state        <= RESP;
              mem_req_q    <= 1'b0;
              mem_we_q     <= 1'b0;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= 2'd0;
            end else begin
              mem_addr_q  <= active.dst + 8'(idx_next);
              mem_wdata_q <= result_buf[{idx_next, 3'b000} +: 8];
            end
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.acc_sel    = active.sel;
  assign bus.acc_op     = active.op;
  assign bus.acc_enable = acc_enable_q;
  assign bus.acc_data   = data_buf;
  assign bus.acc_param  = param_buf;
  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.q_count    = count;
endmodule

// File: tb/tb_accel_dispatch_unit.sv
// Randomised bench for accel_dispatch_unit: memory/accelerator responders plus an in-order
// reference model of what each command must read, write and report.
module tb_accel_dispatch_unit;
  localparam int TIMEOUT = 255;
  localparam int QDEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accel_dispatch_if bus();

  accel_dispatch_unit #(.TIMEOUT(TIMEOUT), .QDEPTH(QDEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic [7:0]   op;
    logic [7:0]   src;
    logic [7:0]   par;
    logic [7:0]   dst;
    int           lat;
    logic         err;
    logic [127:0] result;
  } cmd_s;

  typedef struct packed {
    logic [1:0]   status;
    logic [1:0]   sel;
    logic [7:0]   op;
    logic [127:0] data;
    logic [127:0] param;
    int           en_cyc;
    int           start;
    int           stop;
    int           wr_total;
  } rsp_s;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  rd_q    [$];
  logic [15:0] wr_q    [$];
  rsp_s        rsp_q   [$];
  cmd_s        exp_q   [$];
  cmd_s        acc_q   [$];

  logic        ack_gate  = 1'b1;
  logic        zero_wait = 1'b1;
  int          cyc = 0, start_cyc = 0, en_cnt = 0, rsp_seen = 0, stab_viol = 0, wr_total = 0;
  logic        prev_busy = 1'b0;
  logic        pend = 1'b0;
  logic [17:0] pend_sig = '0;
  logic        acc_run = 1'b0;
  cmd_s        acc_cur;
  int          acc_cycle = 0;

  int           total = 0, bad = 0;
  logic [127:0] exp_data = '0, exp_param = '0;
  int           exp_wr_total = 0, last_stop = 0, last_gap = 0;

  assign bus.mem_ack   = bus.mem_req & ack_gate;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Environment: memory slave, accelerator responder and transaction monitor, all on negedge.
  always @(negedge clk) begin
    logic ack_now;
    rsp_s r;
    cyc++;
    ack_gate = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
    ack_now  = bus.mem_req && ack_gate;
    if (!rst && pend && ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} != pend_sig))
      stab_viol++;
    pend     = !rst && bus.mem_req && !ack_now;
    pend_sig = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    if (ack_now) begin
      if (bus.mem_we) begin
        wr_q.push_back({bus.mem_addr, bus.mem_wdata});
        mem[bus.mem_addr] = bus.mem_wdata;
        wr_total++;
      end else begin
        rd_q.push_back(bus.mem_addr);
      end
    end
    if (bus.busy && !prev_busy) start_cyc = cyc;
    prev_busy = bus.busy;
    if (bus.acc_enable) en_cnt++;
    if (bus.rsp_valid) begin
      r.status   = bus.rsp_status;
      r.sel      = bus.acc_sel;
      r.op       = bus.acc_op;
      r.data     = bus.acc_data;
      r.param    = bus.acc_param;
      r.en_cyc   = en_cnt;
      r.start    = start_cyc;
      r.stop     = cyc;
      r.wr_total = wr_total;
      rsp_q.push_back(r);
      rsp_seen++;
      en_cnt = 0;
    end
    if (bus.acc_enable) begin
      if (!acc_run) begin
        acc_run   = 1'b1;
        acc_cycle = 0;
        if (acc_q.size() > 0) acc_cur = acc_q.pop_front();
        else begin
          acc_cur     = '0;
          acc_cur.lat = 100000;
        end
      end
      bus.acc_result = acc_cur.result;
      bus.acc_error  = acc_cur.err;
      bus.acc_done   = (acc_cycle == acc_cur.lat);
      acc_cycle++;
    end else begin
      acc_run       = 1'b0;
      bus.acc_done  = 1'b0;
      bus.acc_error = 1'b0;
    end
  end

  function automatic cmd_s mk(input logic [1:0] sel, input logic [7:0] src, input logic [7:0] par,
                              input logic [7:0] dst, input int lat, input logic err);
    cmd_s c;
    c.sel    = sel;
    c.op     = 8'($urandom);
    c.src    = src;
    c.par    = par;
    c.dst    = dst;
    c.lat    = lat;
    c.err    = err;
    c.result = {$urandom, $urandom, $urandom, $urandom};
    return c;
  endfunction

  task automatic push_cmd(input cmd_s c);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = c.sel;
    bus.cmd_op    = c.op;
    bus.cmd_src   = c.src;
    bus.cmd_par   = c.par;
    bus.cmd_dst   = c.dst;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      bus.cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(c);
    if (c.sel != 2'd3) acc_q.push_back(c);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // In-order scoreboard: derives each command's reads, writes, status and timing from the rules.
  task automatic score(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      cmd_s        c;
      rsp_s        r;
      int          w, ee, el;
      logic [1:0]  es;
      logic [7:0]  a, d, rd;
      logic [15:0] wr;
      w = 0;
      while (rsp_q.size() == 0 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      total++;
      if (rsp_q.size() == 0 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s_rsp: responses=%0d expected=%0d, required one of each", tag,
                 rsp_q.size(), exp_q.size());
        return;
      end
      r = rsp_q.pop_front();
      c = exp_q.pop_front();
      if (c.sel == 2'd3)       begin es = 2'd3; ee = 0;           el = 1;            end
      else if (c.lat > TIMEOUT) begin es = 2'd2; ee = TIMEOUT + 1; el = 34 + TIMEOUT; end
      else if (c.err)          begin es = 2'd1; ee = c.lat + 1;   el = 34 + c.lat;   end
      else                     begin es = 2'd0; ee = c.lat + 1;   el = 50 + c.lat;   end
      if (c.sel != 2'd3) begin
        for (int i = 0; i < 32; i++) begin
          a = (i < 16) ? c.src + 8'(i) : c.par + 8'(i - 16);
          if (i < 16) exp_data[8*i +: 8] = ref_mem[a];
          else        exp_param[8*(i-16) +: 8] = ref_mem[a];
          total++;
          if (rd_q.size() == 0) begin
            bad++;
            $display("FAIL %s_rd%0d: no read seen, required addr %02h", tag, i, a);
          end else begin
            rd = rd_q.pop_front();
            if (rd !== a) begin
              bad++;
              $display("FAIL %s_rd%0d: addr %02h, required %02h", tag, i, rd, a);
            end
          end
        end
      end
      if (es == 2'd0) begin
        for (int i = 0; i < 16; i++) begin
          a = c.dst + 8'(i);
          d = c.result[8*i +: 8];
          ref_mem[a] = d;
          total++;
          if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL %s_wr%0d: no write seen, required %02h@%02h", tag, i, d, a);
          end else begin
            wr = wr_q.pop_front();
            if (wr !== {a, d}) begin
              bad++;
              $display("FAIL %s_wr%0d: %02h@%02h, required %02h@%02h", tag, i, wr[7:0], wr[15:8], d, a);
            end
          end
        end
        exp_wr_total += 16;
      end
      if (r.status !== es) begin
        bad++;
        $display("FAIL %s_status: %0d, required %0d", tag, r.status, es);
      end
      total++;
      if ({r.sel, r.op} !== {c.sel, c.op}) begin
        bad++;
        $display("FAIL %s_order: sel/op %0d/%02h, required %0d/%02h", tag, r.sel, r.op, c.sel, c.op);
      end
      total++;
      if (r.data !== exp_data || r.param !== exp_param) begin
        bad++;
        $display("FAIL %s_operands: data %032h param %032h, required %032h %032h", tag,
                 r.data, r.param, exp_data, exp_param);
      end
      total++;
      if (r.en_cyc != ee) begin
        bad++;
        $display("FAIL %s_enable_cycles: %0d, required %0d", tag, r.en_cyc, ee);
      end
      total++;
      if (r.wr_total != exp_wr_total) begin
        bad++;
        $display("FAIL %s_write_count: %0d, required %0d", tag, r.wr_total, exp_wr_total);
      end
      if (zero_wait) begin
        total++;
        if (r.stop - r.start + 1 != el) begin
          bad++;
          $display("FAIL %s_latency: %0d, required %0d", tag, r.stop - r.start + 1, el);
        end
      end
      last_gap  = r.start - last_stop;
      last_stop = r.stop;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.acc_enable, bus.busy,
         bus.rsp_valid, bus.rsp_status, bus.q_count, bus.acc_sel, bus.acc_op} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%02h en=%b busy=%b rsp=%b q=%0d, required all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.acc_enable, bus.busy, bus.rsp_valid, bus.q_count);
    end
    total++;
    if ({bus.acc_data, bus.acc_param} !== '0 || bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_buffers: data=%032h ready=%b, required 0 and 1", bus.acc_data, bus.cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: busy=%b ready=%b, required 0 1", bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic test_basic();
    zero_wait = 1'b1;
    push_cmd(mk(2'd1, 8'h10, 8'h40, 8'h80, 3, 1'b0));
    score(1, "basic");
  endtask

  task automatic test_wrap();
    push_cmd(mk(2'd0, 8'hF8, 8'hFC, 8'hF9, 0, 1'b0));
    score(1, "wrap");
  endtask

  task automatic test_timeout();
    push_cmd(mk(2'd2, 8'h20, 8'h30, 8'h50, 100000, 1'b0));
    score(1, "timeout");
    push_cmd(mk(2'd2, 8'h21, 8'h31, 8'h60, TIMEOUT, 1'b0));
    score(1, "done_at_timeout");
  endtask

  task automatic test_error();
    push_cmd(mk(2'd0, 8'h70, 8'h90, 8'hA0, 5, 1'b1));
    score(1, "error");
  endtask

  task automatic test_bad_select();
    push_cmd(mk(2'd3, 8'h11, 8'h22, 8'h33, 2, 1'b0));
    score(1, "bad_sel");
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL bad_sel_traffic: reads=%0d writes=%0d, required 0 0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    push_cmd(mk(2'd1, 8'h05, 8'h15, 8'hC0, 1, 1'b0));
    push_cmd(mk(2'd0, 8'h25, 8'h35, 8'hD0, 2, 1'b0));
    score(2, "b2b");
    total++;
    if (last_gap != 2) begin
      bad++;
      $display("FAIL b2b_gap: %0d cycles RESP to next busy, required 2", last_gap);
    end
  endtask

  task automatic test_backpressure();
    int n, seen0;
    seen0 = rsp_seen;
    push_cmd(mk(2'd1, 8'h40, 8'h50, 8'hB0, 60, 1'b0));
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) push_cmd(mk(2'(i % 3), 8'(8'h60 + 8'(i)), 8'h08, 8'(8'hE0 + 8'(i)), i, 1'b0));
    @(negedge clk);
    total++;
    if (bus.q_count !== 4'd4 || bus.cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_queue: q_count=%0d ready=%b, required 4 0", bus.q_count, bus.cmd_ready);
    end
    push_cmd(mk(2'd2, 8'h99, 8'hAA, 8'h00, 4, 1'b0));
    total++;
    if (rsp_seen - seen0 != 1) begin
      bad++;
      $display("FAIL fifth_accept: %0d completions before accept, required 1", rsp_seen - seen0);
    end
    score(6, "fifo");
  endtask

  task automatic test_reset_mid_load();
    int n;
    push_cmd(mk(2'd1, 8'h30, 8'h48, 8'h58, 5, 1'b0));
    push_cmd(mk(2'd0, 8'h31, 8'h49, 8'h59, 5, 1'b0));
    push_cmd(mk(2'd2, 8'h32, 8'h4A, 8'h5A, 5, 1'b0));
    n = 0;
    while (rd_q.size() < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.mem_req !== 1'b1 || rd_q.size() < 20) begin
      bad++;
      $display("FAIL mid_load_setup: mem_req=%b reads=%0d, required 1 and >=20", bus.mem_req, rd_q.size());
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.acc_enable !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL async_abort: mem_req=%b en=%b busy=%b, required 0 0 0",
               bus.mem_req, bus.acc_enable, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    rd_q.delete();
    rsp_q.delete();
    exp_data     = '0;
    exp_param    = '0;
    exp_wr_total = wr_total;
    @(negedge clk);
    total++;
    if (bus.q_count !== 4'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.acc_data !== '0) begin
      bad++;
      $display("FAIL post_reset: q=%0d busy=%b ready=%b data=%032h, required 0 0 1 0",
               bus.q_count, bus.busy, bus.cmd_ready, bus.acc_data);
    end
  endtask

  task automatic test_random();
    logic [1:0] s;
    zero_wait = 1'b0;
    for (int i = 0; i < 14; i++) begin
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      push_cmd(mk(s, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 12),
                  ($urandom_range(0, 4) == 0)));
    end
    score(14, "rand");
    zero_wait = 1'b1;
  endtask

  task automatic test_final();
    int diff;
    diff = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    total++;
    if (diff != 0) begin
      bad++;
      $display("FAIL memory_image: %0d bytes differ, required 0", diff);
    end
    total++;
    if (stab_viol != 0) begin
      bad++;
      $display("FAIL handshake_stability: %0d violations, required 0", stab_viol);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_op    = '0;
    bus.cmd_src   = '0;
    bus.cmd_par   = '0;
    bus.cmd_dst   = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_error();
    test_bad_select();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_load();
    test_random();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
